// File: rtl/adder_result_checker.sv
// adder_result_checker: response monitor for a 16-bit adder under test.
// Captures each stimulus, delays a golden {cout,sum} by LATENCY cycles and
// compares it with the DUT result, keeping saturating pass/fail counters,
// a sticky error flag and a per-mismatch pulse.
// Optional feature macro: ADDER_CHK_FAILLOG_EN (first-failure capture ports).
module adder_result_checker #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
`ifdef ADDER_CHK_FAILLOG_EN
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin,
  output logic [WIDTH:0]   fail_sum,
`endif
  output logic             mismatch
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_r;
  logic             acc_s;
  logic             clear_s;
  logic             cmp_vld_s;
  logic             drain_empty_s;
  logic             match_s;
  logic [WIDTH:0]   gold_s;
  logic [WIDTH:0]   cmp_gold_s;
  logic [WIDTH:0]   obs_s;
  logic [CNT_W-1:0] cnt_max_s;
  logic [CNT_W-1:0] cnt_one_s;
`ifdef ADDER_CHK_FAILLOG_EN
  logic [WIDTH-1:0] cmp_a_s;
  logic [WIDTH-1:0] cmp_b_s;
  logic             cmp_cin_s;
`endif

  // Stimulus is only accepted while running; zeros enter the delay line otherwise.
  assign acc_s     = (state_r == S_RUN) && in_valid;
  assign clear_s   = start && ((state_r == S_IDLE) || (state_r == S_DONE));
  assign gold_s    = acc_s ? ({1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin})
                           : {(WIDTH+1){1'b0}};
  assign obs_s     = {dut_cout, dut_sum};
  assign match_s   = (cmp_gold_s == obs_s);
  assign cnt_max_s = {CNT_W{1'b1}};
  assign cnt_one_s = {{(CNT_W-1){1'b0}}, 1'b1};

  generate
    if (LATENCY == 0) begin : g_nodelay
      // Zero latency: compare against the stimulus sampled on the same edge.
      assign cmp_vld_s     = acc_s;
      assign cmp_gold_s    = gold_s;
      assign drain_empty_s = 1'b1;
`ifdef ADDER_CHK_FAILLOG_EN
      assign cmp_a_s   = in_a;
      assign cmp_b_s   = in_b;
      assign cmp_cin_s = in_cin;
`endif
    end else begin : g_delay
      logic [WIDTH:0]     gold_r [LATENCY];
      logic [LATENCY-1:0] vld_r;
      logic               pend_s;
`ifdef ADDER_CHK_FAILLOG_EN
      logic [WIDTH-1:0]   a_r [LATENCY];
      logic [WIDTH-1:0]   b_r [LATENCY];
      logic [LATENCY-1:0] cin_r;
`endif

      // Delay line: shifts golden/valid (and operands) one stage per cycle.
      always_ff @(posedge clk) begin
        if (rst || clear_s) begin
          vld_r <= {LATENCY{1'b0}};
          for (int i = 0; i < LATENCY; i++) begin
            gold_r[i] <= {(WIDTH+1){1'b0}};
          end
`ifdef ADDER_CHK_FAILLOG_EN
          cin_r <= {LATENCY{1'b0}};
          for (int i = 0; i < LATENCY; i++) begin
            a_r[i] <= {WIDTH{1'b0}};
            b_r[i] <= {WIDTH{1'b0}};
          end
`endif
        end else begin
          vld_r[0]  <= acc_s;
          gold_r[0] <= gold_s;
          for (int i = 1; i < LATENCY; i++) begin
            vld_r[i]  <= vld_r[i-1];
            gold_r[i] <= gold_r[i-1];
          end
`ifdef ADDER_CHK_FAILLOG_EN
          a_r[0]   <= acc_s ? in_a : {WIDTH{1'b0}};
          b_r[0]   <= acc_s ? in_b : {WIDTH{1'b0}};
          cin_r[0] <= acc_s & in_cin;
          for (int i = 1; i < LATENCY; i++) begin
            a_r[i]   <= a_r[i-1];
            b_r[i]   <= b_r[i-1];
            cin_r[i] <= cin_r[i-1];
          end
`endif
        end
      end

      // Entries that will still be in flight after the current edge.
      always_comb begin
        pend_s = 1'b0;
        for (int i = 0; i < LATENCY - 1; i++) begin
          pend_s = pend_s | vld_r[i];
        end
      end

      assign cmp_vld_s     = vld_r[LATENCY-1];
      assign cmp_gold_s    = gold_r[LATENCY-1];
      assign drain_empty_s = ~pend_s;
`ifdef ADDER_CHK_FAILLOG_EN
      assign cmp_a_s   = a_r[LATENCY-1];
      assign cmp_b_s   = b_r[LATENCY-1];
      assign cmp_cin_s = cin_r[LATENCY-1];
`endif
    end
  endgenerate

  // Control FSM, compare bookkeeping and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass_cnt <= {CNT_W{1'b0}};
      fail_cnt <= {CNT_W{1'b0}};
      err      <= 1'b0;
      mismatch <= 1'b0;
`ifdef ADDER_CHK_FAILLOG_EN
      fail_a   <= {WIDTH{1'b0}};
      fail_b   <= {WIDTH{1'b0}};
      fail_cin <= 1'b0;
      fail_sum <= {(WIDTH+1){1'b0}};
`endif
    end else begin
      mismatch <= 1'b0;
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_r <= S_RUN;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_r <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_empty_s) begin
            state_r <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase

      if (clear_s) begin
        pass_cnt <= {CNT_W{1'b0}};
        fail_cnt <= {CNT_W{1'b0}};
        err      <= 1'b0;
`ifdef ADDER_CHK_FAILLOG_EN
        fail_a   <= {WIDTH{1'b0}};
        fail_b   <= {WIDTH{1'b0}};
        fail_cin <= 1'b0;
        fail_sum <= {(WIDTH+1){1'b0}};
`endif
      end else if (cmp_vld_s) begin
        if (match_s) begin
          if (pass_cnt != cnt_max_s) begin
            pass_cnt <= pass_cnt + cnt_one_s;
          end
        end else begin
          if (fail_cnt != cnt_max_s) begin
            fail_cnt <= fail_cnt + cnt_one_s;
          end
          err      <= 1'b1;
          mismatch <= 1'b1;
`ifdef ADDER_CHK_FAILLOG_EN
          // Only the first failure of a run is kept.
          if (!err) begin
            fail_a   <= cmp_a_s;
            fail_b   <= cmp_b_s;
            fail_cin <= cmp_cin_s;
            fail_sum <= obs_s;
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed testbench for adder_result_checker: a LATENCY=0 instance, a
// LATENCY=3 instance fed by a 3-stage stand-in adder, and a CNT_W=4 instance.
module tb_adder_result_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, stop, in_valid, in_cin, fault;
  logic [15:0] in_a, in_b;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Stand-in adders: combinational for LATENCY=0, pipelined for LATENCY=3.
  logic [16:0] model0;
  logic [16:0] pipe3 [3];
  logic [15:0] sum0;
  logic        cout0;
  assign model0 = {1'b0, in_a} + {1'b0, in_b} + {16'd0, in_cin};
  assign sum0   = model0[15:0];
  assign cout0  = fault ? 1'b0 : model0[16];
  always @(posedge clk) begin
    pipe3[0] <= model0;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  logic        busy0, done0, err0, mm0, busy3, done3, err3, mm3, busy4, done4, err4, mm4;
  logic [15:0] pass0, fail0, pass3, fail3;
  logic [3:0]  pass4, fail4;
`ifdef ADDER_CHK_FAILLOG_EN
  logic [15:0] fa0, fb0, fa3, fb3, fa4, fb4;
  logic        fc0, fc3, fc4;
  logic [16:0] fs0, fs3, fs4;
`endif

  adder_result_checker #(.WIDTH(16), .LATENCY(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .dut_sum(sum0), .dut_cout(cout0),
    .busy(busy0), .done(done0), .pass_cnt(pass0), .fail_cnt(fail0), .err(err0),
`ifdef ADDER_CHK_FAILLOG_EN
    .fail_a(fa0), .fail_b(fb0), .fail_cin(fc0), .fail_sum(fs0),
`endif
    .mismatch(mm0));

  adder_result_checker #(.WIDTH(16), .LATENCY(3), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .dut_sum(pipe3[2][15:0]), .dut_cout(pipe3[2][16]),
    .busy(busy3), .done(done3), .pass_cnt(pass3), .fail_cnt(fail3), .err(err3),
`ifdef ADDER_CHK_FAILLOG_EN
    .fail_a(fa3), .fail_b(fb3), .fail_cin(fc3), .fail_sum(fs3),
`endif
    .mismatch(mm3));

  adder_result_checker #(.WIDTH(16), .LATENCY(0), .CNT_W(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .dut_sum(sum0), .dut_cout(cout0),
    .busy(busy4), .done(done4), .pass_cnt(pass4), .fail_cnt(fail4), .err(err4),
`ifdef ADDER_CHK_FAILLOG_EN
    .fail_a(fa4), .fail_b(fb4), .fail_cin(fc4), .fail_sum(fs4),
`endif
    .mismatch(mm4));

  logic [15:0] va [4] = '{16'h52A0, 16'hB904, 16'h158A, 16'h8194};
  logic [15:0] vb [4] = '{16'h9A44, 16'hC6B4, 16'h7094, 16'h1314};
  logic        vc [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic v);
    in_a = va[i]; in_b = vb[i]; in_cin = vc[i]; in_valid = v;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_a = 16'h0000; in_b = 16'h0000; in_cin = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; fault = 1'b0; idle_in();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; stop = 1'b0; fault = 1'b0; idle_in();
    tick(); tick();
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy0); end
    n_cmp++; if (done0 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done0); end
    n_cmp++; if (pass0 !== 16'h0000 || fail0 !== 16'h0000) begin n_bad++; $display("FAIL reset_cnt: got %h/%h want 0/0", pass0, fail0); end
    n_cmp++; if (err0 !== 1'b0 || mm0 !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b/%b want 0/0", err0, mm0); end
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++; if (busy0 !== 1'b1 || done0 !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %b/%b want 1/0", busy0, done0); end
    set_vec(3, 1'b1); tick(); idle_in();
    n_cmp++; if (pass0 !== 16'd1) begin n_bad++; $display("FAIL single_pass: got %0d want 1", pass0); end
    n_cmp++; if (err0 !== 1'b0 || fail0 !== 16'd0) begin n_bad++; $display("FAIL single_err: got %b/%0d want 0/0", err0, fail0); end
    stop = 1'b1; tick(); stop = 1'b0; tick();
    n_cmp++; if (done0 !== 1'b1 || busy0 !== 1'b0) begin n_bad++; $display("FAIL single_done: got %b/%b want 1/0", done0, busy0); end
  endtask

  task automatic test_four();
    apply_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin set_vec(i, 1'b1); tick(); end
    idle_in(); stop = 1'b1; tick(); stop = 1'b0;
    set_vec(0, 1'b1); tick(); idle_in();
    n_cmp++; if (pass0 !== 16'd4 || fail0 !== 16'd0) begin n_bad++; $display("FAIL four_cnt: got %0d/%0d want 4/0", pass0, fail0); end
    n_cmp++; if (done0 !== 1'b1) begin n_bad++; $display("FAIL four_done: got %b want 1", done0); end
  endtask

  task automatic test_fault();
    int pulses;
    pulses = 0;
    apply_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_vec(i, 1'b1); fault = (i == 1); tick();
      if (mm0 === 1'b1) pulses++;
      if (i == 1) begin
        n_cmp++; if (mm0 !== 1'b1) begin n_bad++; $display("FAIL fault_pulse_at: got %b want 1", mm0); end
      end
    end
    idle_in(); fault = 1'b0; tick();
    if (mm0 === 1'b1) pulses++;
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL fault_pulses: got %0d want 1", pulses); end
    n_cmp++; if (fail0 !== 16'd1 || pass0 !== 16'd3) begin n_bad++; $display("FAIL fault_cnt: got %0d/%0d want 1/3", fail0, pass0); end
    n_cmp++; if (err0 !== 1'b1) begin n_bad++; $display("FAIL fault_err: got %b want 1", err0); end
`ifdef ADDER_CHK_FAILLOG_EN
    n_cmp++; if (fa0 !== 16'hB904 || fb0 !== 16'hC6B4 || fc0 !== 1'b0) begin n_bad++; $display("FAIL faillog_vec: got %h %h %b want B904 C6B4 0", fa0, fb0, fc0); end
    n_cmp++; if (fs0 !== 17'h07FB8) begin n_bad++; $display("FAIL faillog_sum: got %h want 07FB8", fs0); end
`endif
  endtask

  task automatic test_latency3();
    int cnt;
    cnt = 0;
    apply_reset();
    start = 1'b1; tick(); start = 1'b0;
    set_vec(0, 1'b1); tick();
    set_vec(1, 1'b1); tick();
    set_vec(2, 1'b1); stop = 1'b1; tick();
    idle_in(); stop = 1'b0;
    n_cmp++; if (busy3 !== 1'b1 || pass3 !== 16'd0) begin n_bad++; $display("FAIL lat3_stop: got busy %b pass %0d want 1/0", busy3, pass3); end
    for (int k = 0; k < 20; k++) begin
      if (busy3 !== 1'b1) break;
      cnt++;
      tick();
    end
    n_cmp++; if (cnt !== 3) begin n_bad++; $display("FAIL lat3_busy_cycles: got %0d want 3", cnt); end
    n_cmp++; if (done3 !== 1'b1) begin n_bad++; $display("FAIL lat3_done: got %b want 1", done3); end
    n_cmp++; if (pass3 !== 16'd3 || fail3 !== 16'd0) begin n_bad++; $display("FAIL lat3_cnt: got %0d/%0d want 3/0", pass3, fail3); end
  endtask

  task automatic test_saturation();
    apply_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_vec(i % 4, 1'b1); tick();
      if (i == 14) begin
        n_cmp++; if (pass4 !== 4'hF) begin n_bad++; $display("FAIL sat_reach: got %h want F", pass4); end
      end
    end
    idle_in();
    n_cmp++; if (pass4 !== 4'hF || fail4 !== 4'h0) begin n_bad++; $display("FAIL sat_hold: got %h/%h want F/0", pass4, fail4); end
    n_cmp++; if (pass0 !== 16'd20) begin n_bad++; $display("FAIL sat_wide: got %0d want 20", pass0); end
  endtask

  task automatic test_reset_midrun();
    apply_reset();
    start = 1'b1; tick(); start = 1'b0;
    set_vec(0, 1'b1); tick();
    set_vec(1, 1'b1); tick();
    idle_in(); rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (busy3 !== 1'b0 || pass3 !== 16'd0) begin n_bad++; $display("FAIL midrst_state: got busy %b pass %0d want 0/0", busy3, pass3); end
    for (int k = 0; k < 5; k++) tick();
    n_cmp++; if (pass3 !== 16'd0 || fail3 !== 16'd0) begin n_bad++; $display("FAIL midrst_late: got %0d/%0d want 0/0", pass3, fail3); end
    start = 1'b1; tick(); start = 1'b0;
    set_vec(2, 1'b1); tick(); idle_in();
    tick(); tick(); tick();
    n_cmp++; if (pass3 !== 16'd1 || fail3 !== 16'd0) begin n_bad++; $display("FAIL midrst_restart: got %0d/%0d want 1/0", pass3, fail3); end
  endtask

  task automatic test_start_stop();
    apply_reset();
    stop = 1'b1; tick(); stop = 1'b0;
    n_cmp++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin n_bad++; $display("FAIL ss_idle_stop: got %b/%b want 0/0", busy0, done0); end
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0; tick();
    n_cmp++; if (busy0 !== 1'b1 || done0 !== 1'b0) begin n_bad++; $display("FAIL ss_idle_both: got %b/%b want 1/0", busy0, done0); end
    stop = 1'b1; tick(); stop = 1'b0; tick();
    n_cmp++; if (done0 !== 1'b1 || busy0 !== 1'b0) begin n_bad++; $display("FAIL ss_done: got %b/%b want 1/0", done0, busy0); end
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0; tick();
    n_cmp++; if (busy0 !== 1'b1 || done0 !== 1'b0) begin n_bad++; $display("FAIL ss_done_both: got %b/%b want 1/0", busy0, done0); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; fault = 1'b0; idle_in();
    test_reset();
    test_single();
    test_four();
    test_fault();
    test_latency3();
    test_saturation();
    test_reset_midrun();
    test_start_stop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
